// File: rtl/accel_pkg.sv
// Shared definitions for the matmul tile sequencer: FSM states, buffer latency,
// default widths and the drain-length helper.
package accel_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadWt,
    StStream,
    StDrain,
    StWriteback,
    StDone
  } seq_state_e;

  localparam int unsigned BUF_RD_LAT     = 1;
  localparam int unsigned DEF_ADDR_W     = 15;
  localparam int unsigned DEF_OPB_ADDR_W = 4;
  localparam int unsigned DEF_K_W        = 8;

  // One cycle for the last buffer read to land, then 2N-1 cycles of skew flush.
  function automatic int unsigned drain_len(input int unsigned arr_size);
    return BUF_RD_LAT + 2 * arr_size - 1;
  endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// Loadable up-counter shared by all sequencer phases. A load clears the count
// and captures the phase length; last flags the final cycle of the phase.
module seq_phase_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] count_q;
  logic [W-1:0] limit_q;

  // Load has priority over counting so a phase can end and the next begin together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= '0;
    end else if (load) begin
      count_q <= '0;
      limit_q <= limit;
    end else if (en) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;
  assign last  = (count_q == limit_q - W'(1));

endmodule

// File: rtl/matmul_sequencer.sv
// Tile-level scheduler for one systolic matrix multiply: clear, load weights,
// stream inputs, drain the skewed array, write accumulated rows back.
// Optional build macro MATMUL_SEQ_PERF_EN adds the perf_cycles busy-cycle counter.
module matmul_sequencer
  import accel_pkg::*;
#(
  parameter int unsigned ARR_SIZE   = 4,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned OPB_ADDR_W = DEF_OPB_ADDR_W,
  parameter int unsigned K_W        = DEF_K_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     cfg_wt_base,
  input  logic [ADDR_W-1:0]     cfg_inp_base,
  input  logic [K_W-1:0]        cfg_k_len,
  input  logic [OPB_ADDR_W-1:0] cfg_op_addr,
  input  logic                  opb_stall,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_clear,
  output logic                  wt_rd_en,
  output logic [ADDR_W-1:0]     wt_rd_addr,
  output logic                  arr_load_wt,
  output logic                  inp_rd_en,
  output logic [ADDR_W-1:0]     inp_rd_addr,
  output logic                  arr_valid,
  output logic                  acc_wr_en,
  output logic [OPB_ADDR_W-1:0] acc_op_addr
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int unsigned DRAIN_LEN = drain_len(ARR_SIZE);
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN) + 1;
  localparam int unsigned CNT_W     = (K_W > DRAIN_W) ? K_W : DRAIN_W;

  seq_state_e state_q, state_d;

  logic [ADDR_W-1:0]     wt_base_q;
  logic [ADDR_W-1:0]     inp_base_q;
  logic [K_W-1:0]        k_len_q;
  logic [OPB_ADDR_W-1:0] op_addr_q;

  logic             cfg_latch;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  seq_phase_counter #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .en    (cnt_en),
    .limit (cnt_limit),
    .count (cnt),
    .last  (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Tile configuration is captured only when a start is accepted in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_base_q  <= '0;
      inp_base_q <= '0;
      k_len_q    <= '0;
      op_addr_q  <= '0;
    end else if (cfg_latch) begin
      wt_base_q  <= cfg_wt_base;
      inp_base_q <= cfg_inp_base;
      k_len_q    <= cfg_k_len;
      op_addr_q  <= cfg_op_addr;
    end
  end

  // Buffer data arrives one cycle after the read strobe; the array consumes it then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_load_wt <= 1'b0;
      arr_valid   <= 1'b0;
    end else begin
      arr_load_wt <= wt_rd_en;
      arr_valid   <= inp_rd_en;
    end
  end

  // Phase sequencing: each phase reloads the shared counter with its own length.
  always_comb begin
    state_d   = state_q;
    cfg_latch = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_limit = '0;
    acc_clear = 1'b0;
    wt_rd_en  = 1'b0;
    inp_rd_en = 1'b0;
    acc_wr_en = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_latch = 1'b1;
          acc_clear = 1'b1;
          if (cfg_k_len == '0) begin
            state_d = StDone;
          end else begin
            state_d   = StLoadWt;
            cnt_load  = 1'b1;
            cnt_limit = CNT_W'(ARR_SIZE);
          end
        end
      end
      StLoadWt: begin
        wt_rd_en = 1'b1;
        cnt_en   = 1'b1;
        if (cnt_last) begin
          state_d   = StStream;
          cnt_load  = 1'b1;
          cnt_limit = CNT_W'(k_len_q);
        end
      end
      StStream: begin
        inp_rd_en = 1'b1;
        cnt_en    = 1'b1;
        if (cnt_last) begin
          state_d   = StDrain;
          cnt_load  = 1'b1;
          cnt_limit = CNT_W'(DRAIN_LEN);
        end
      end
      StDrain: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d   = StWriteback;
          cnt_load  = 1'b1;
          cnt_limit = CNT_W'(ARR_SIZE);
        end
      end
      StWriteback: begin
        // A stalled cycle neither writes nor advances the row index.
        if (!opb_stall) begin
          acc_wr_en = 1'b1;
          cnt_en    = 1'b1;
          if (cnt_last) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign wt_rd_addr  = wt_rd_en  ? (wt_base_q + ADDR_W'(cnt))      : '0;
  assign inp_rd_addr = inp_rd_en ? (inp_base_q + ADDR_W'(cnt))     : '0;
  assign acc_op_addr = acc_wr_en ? (op_addr_q + OPB_ADDR_W'(cnt))  : '0;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_q;
  logic [31:0] perf_inc;

  assign perf_inc = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;

  // Counts busy cycles of the current tile; the done cycle itself is included in the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      if (cfg_latch) begin
        perf_cnt_q <= '0;
      end else if (busy) begin
        perf_cnt_q <= perf_inc;
      end
      if (done) begin
        perf_q <= perf_inc;
      end
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed scenarios plus randomized
// tiles, each cycle compared against a cycle-window model of the tile schedule.
module tb_matmul_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] cfg_wt_base;
  logic [14:0] cfg_inp_base;
  logic [7:0]  cfg_k_len;
  logic [3:0]  cfg_op_addr;
  logic        opb_stall;
  logic        busy;
  logic        done;
  logic        acc_clear;
  logic        wt_rd_en;
  logic [14:0] wt_rd_addr;
  logic        arr_load_wt;
  logic        inp_rd_en;
  logic [14:0] inp_rd_addr;
  logic        arr_valid;
  logic        acc_wr_en;
  logic [3:0]  acc_op_addr;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int last_done_t = 0;

  always #5 clk = ~clk;

  matmul_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_wt_base  (cfg_wt_base),
    .cfg_inp_base (cfg_inp_base),
    .cfg_k_len    (cfg_k_len),
    .cfg_op_addr  (cfg_op_addr),
    .opb_stall    (opb_stall),
    .busy         (busy),
    .done         (done),
    .acc_clear    (acc_clear),
    .wt_rd_en     (wt_rd_en),
    .wt_rd_addr   (wt_rd_addr),
    .arr_load_wt  (arr_load_wt),
    .inp_rd_en    (inp_rd_en),
    .inp_rd_addr  (inp_rd_addr),
    .arr_valid    (arr_valid),
    .acc_wr_en    (acc_wr_en),
    .acc_op_addr  (acc_op_addr)
`ifdef MATMUL_SEQ_PERF_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input logic e_clr, input logic e_wt, input logic [14:0] e_wa,
                           input logic e_inp, input logic [14:0] e_ia, input logic e_lw,
                           input logic e_av, input logic e_wr, input logic [3:0] e_oa,
                           input logic e_done, input logic e_busy);
    chk("acc_clear", 32'(acc_clear), 32'(e_clr));
    chk("wt_rd_en", 32'(wt_rd_en), 32'(e_wt));
    chk("wt_rd_addr", 32'(wt_rd_addr), 32'(e_wa));
    chk("inp_rd_en", 32'(inp_rd_en), 32'(e_inp));
    chk("inp_rd_addr", 32'(inp_rd_addr), 32'(e_ia));
    chk("arr_load_wt", 32'(arr_load_wt), 32'(e_lw));
    chk("arr_valid", 32'(arr_valid), 32'(e_av));
    chk("acc_wr_en", 32'(acc_wr_en), 32'(e_wr));
    chk("acc_op_addr", 32'(acc_op_addr), 32'(e_oa));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  // mode: 0 no stall, 1 stall window [s0, s0+slen), 2 random stall every cycle.
  task automatic run(input logic [14:0] wb, input logic [14:0] ib, input logic [7:0] k,
                     input logic [3:0] op, input int mode, input int s0, input int slen,
                     input int restart_at);
    int          wbs;
    int          rows;
    int          done_t;
    int          t;
    logic        e_wt, e_inp, e_lw, e_av, e_wr;
    logic [14:0] e_wa, e_ia;
    logic [3:0]  e_oa;
    wbs    = 3 * N + int'(k) + 1;
    rows   = 0;
    done_t = (k == 8'd0) ? 1 : -1;
    @(posedge clk);
    #1;
    start        = 1'b1;
    cfg_wt_base  = wb;
    cfg_inp_base = ib;
    cfg_k_len    = k;
    cfg_op_addr  = op;
    opb_stall    = 1'($urandom);
    @(negedge clk);
    check_all(1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles, 32'(last_done_t));
`endif
    t = 0;
    while (done_t < 0 || t < done_t) begin
      t++;
      if (t > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout: no done after %0d cycles, expected done_t %0d", t, done_t);
        break;
      end
      @(posedge clk);
      #1;
      start        = (t == restart_at);
      cfg_wt_base  = 15'($urandom);
      cfg_inp_base = 15'($urandom);
      cfg_k_len    = 8'($urandom);
      cfg_op_addr  = 4'($urandom);
      case (mode)
        1:       opb_stall = (t >= s0 && t < s0 + slen);
        2:       opb_stall = ($urandom_range(0, 2) == 0);
        default: opb_stall = 1'b0;
      endcase
      @(negedge clk);
      e_wt  = (k != 8'd0) && t <= N;
      e_wa  = e_wt ? wb + 15'(t - 1) : 15'd0;
      e_inp = (k != 8'd0) && t > N && t <= N + int'(k);
      e_ia  = e_inp ? ib + 15'(t - N - 1) : 15'd0;
      e_lw  = (k != 8'd0) && t >= 2 && t <= N + 1;
      e_av  = (k != 8'd0) && t >= N + 2 && t <= N + int'(k) + 1;
      e_wr  = (k != 8'd0) && t >= wbs && rows < N && !opb_stall;
      e_oa  = e_wr ? op + 4'(rows) : 4'd0;
      check_all(1'b0, e_wt, e_wa, e_inp, e_ia, e_lw, e_av, e_wr, e_oa, (t == done_t), 1'b1);
      if (e_wr) begin
        rows++;
        if (rows == N) done_t = t + 1;
      end
    end
    start       = 1'b0;
    last_done_t = done_t;
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    cfg_wt_base  = '0;
    cfg_inp_base = '0;
    cfg_k_len    = '0;
    cfg_op_addr  = '0;
    opb_stall    = 1'b0;
    #12;
    check_all(1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reference tile: done 25 cycles after start.
    run(15'h0010, 15'h0100, 8'd8, 4'd2, 0, 0, 0, -1);
    chk("latency_basic", 32'(last_done_t), 32'd25);

    // Address wrap on weight buffer, input buffer and output slots.
    run(15'h7FFE, 15'h7FFD, 8'd5, 4'd14, 0, 0, 0, -1);

    // Zero-length tile.
    run(15'h0123, 15'h0456, 8'd0, 4'd7, 0, 0, 0, -1);
    chk("latency_k0", 32'(last_done_t), 32'd1);

    // Three stalled cycles starting at the second writeback cycle.
    run(15'h0010, 15'h0100, 8'd8, 4'd2, 1, 22, 3, -1);
    chk("latency_stall", 32'(last_done_t), 32'd28);

    // start re-pulsed mid-stream with different cfg must be ignored.
    run(15'h0200, 15'h0300, 8'd6, 4'd9, 0, 0, 0, N + 2);

    // Reset in the middle of STREAM.
    @(posedge clk);
    #1;
    start        = 1'b1;
    cfg_wt_base  = 15'h0040;
    cfg_inp_base = 15'h0500;
    cfg_k_len    = 8'd8;
    cfg_op_addr  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all(1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("perf_reset", perf_cycles, 32'd0);
`endif
    last_done_t = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(15'h0040, 15'h0500, 8'd8, 4'd3, 0, 0, 0, -1);
    chk("latency_after_reset", 32'(last_done_t), 32'd25);

    // Randomized tiles with random stalls and occasional ignored restarts.
    for (int r = 0; r < 8; r++) begin
      run(15'($urandom), 15'($urandom), 8'($urandom_range(0, 20)), 4'($urandom), 2, 0, 0,
          int'($urandom_range(1, 30)));
    end

    @(posedge clk);
    #1;
    @(negedge clk);
    chk("busy_final", 32'(busy), 32'd0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("perf_final", perf_cycles, 32'(last_done_t));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
